muldiv_div_sequencer: RTL and testbench

- Multi-cycle controller and datapath for the RV32M divide/remainder operations: DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation per start pulse and runs a radix-2 restoring division over XLEN iterations.
- Holds the pipeline stall until the result is ready, then presents the result for exactly one cycle.

---
 rtl/muldiv_div_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_div_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_div_sequencer.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring division over XLEN
// iterations, with sign correction and the RISC-V divide-by-zero / overflow results.
module muldiv_div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            iCLK,
    input  logic            iRST_n,
    input  logic            iStart,
    input  logic [1:0]      iOp,
    input  logic [XLEN-1:0] iDividend,
    input  logic [XLEN-1:0] iDivisor,
    input  logic            iKill,
    output logic            oBusy,
    output logic            oStall,
    output logic            oDone,
    output logic [XLEN-1:0] oResult
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO_V = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_V = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE_V  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            op_rem_r;
    logic            neg_q_r;
    logic            neg_rem_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] result_r;

    logic            accept_s;
    logic            is_signed_s;
    logic            dnd_neg_s;
    logic            dvs_neg_s;
    logic [XLEN-1:0] dnd_mag_s;
    logic [XLEN-1:0] dvs_mag_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic [XLEN-1:0] special_res_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;
    logic            fits_s;
    logic [XLEN-1:0] fix_q_s;
    logic [XLEN-1:0] fix_rem_s;
    logic [XLEN-1:0] fix_res_s;

    // Operand decode at acceptance: magnitudes, sign flags and the two special results
    always_comb begin
        accept_s    = (state_r == IDLE) & iStart & ~iKill;
        is_signed_s = ~iOp[0];
        dnd_neg_s   = is_signed_s & iDividend[XLEN-1];
        dvs_neg_s   = is_signed_s & iDivisor[XLEN-1];
        dnd_mag_s   = dnd_neg_s ? (~iDividend + ONE_V) : iDividend;
        dvs_mag_s   = dvs_neg_s ? (~iDivisor + ONE_V) : iDivisor;
        div_zero_s  = (iDivisor == ZERO_V);
        ovf_s       = is_signed_s & (iDividend == MIN_V) & (iDivisor == ONES_V);
        if (div_zero_s) begin
            special_res_s = iOp[1] ? iDividend : ONES_V;
        end else begin
            special_res_s = iOp[1] ? ZERO_V : MIN_V;
        end
    end

    // One restoring step; the shifted remainder is below twice the divisor,
    // so bit XLEN of the difference is a reliable borrow flag
    always_comb begin
        shifted_s = {rem_r, quo_r[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        fits_s    = ~diff_s[XLEN];
        fix_q_s   = neg_q_r ? (~quo_r + ONE_V) : quo_r;
        fix_rem_s = neg_rem_r ? (~rem_r + ONE_V) : rem_r;
        fix_res_s = op_rem_r ? fix_rem_s : fix_q_s;
    end

    // Next-state and stall logic
    always_comb begin
        state_s = state_r;
        oStall  = 1'b0;
        case (state_r)
            IDLE: begin
                oStall = accept_s;
                if (accept_s) begin
                    state_s = (div_zero_s | ovf_s) ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                oStall = 1'b1;
                if (iKill) begin
                    state_s = IDLE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                oStall = 1'b1;
                if (iKill) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: operand latch, iteration, and result capture on entry to DONE
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            op_rem_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            dvs_r     <= ZERO_V;
            quo_r     <= ZERO_V;
            rem_r     <= ZERO_V;
            cnt_r     <= {CW{1'b0}};
            result_r  <= ZERO_V;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_rem_r  <= iOp[1];
                        neg_q_r   <= dnd_neg_s ^ dvs_neg_s;
                        neg_rem_r <= dnd_neg_s;
                        dvs_r     <= dvs_mag_s;
                        quo_r     <= dnd_mag_s;
                        rem_r     <= ZERO_V;
                        cnt_r     <= CNT_INIT;
                        if (div_zero_s | ovf_s) begin
                            result_r <= special_res_s;
                        end
                    end
                end
                CALC: begin
                    if (!iKill) begin
                        rem_r <= fits_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
                        quo_r <= {quo_r[XLEN-2:0], fits_s};
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                FIX: begin
                    if (!iKill) begin
                        result_r <= fix_res_s;
                    end
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign oBusy   = (state_r != IDLE);
    assign oDone   = (state_r == DONE);
    assign oResult = result_r;

endmodule

// File: tb/tb_muldiv_div_sequencer.sv
// Directed and randomized bench for muldiv_div_sequencer, checked against an
// arithmetic reference model of the RV32M divide/remainder rules.
module tb_muldiv_div_sequencer;

    logic        iCLK;
    logic        iRST_n;
    logic        iStart;
    logic [1:0]  iOp;
    logic [31:0] iDividend;
    logic [31:0] iDivisor;
    logic        iKill;
    logic        oBusy;
    logic        oStall;
    logic        oDone;
    logic [31:0] oResult;

    int tests_run = 0;
    int tests_failed = 0;

    muldiv_div_sequencer #(.XLEN(32)) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iStart    (iStart),
        .iOp       (iOp),
        .iDividend (iDividend),
        .iDivisor  (iDivisor),
        .iKill     (iKill),
        .oBusy     (oBusy),
        .oStall    (oStall),
        .oDone     (oDone),
        .oResult   (oResult)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa;
        int sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!op[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 34;
    endfunction

    // Start an operation in the current (IDLE) cycle; cycle 0 is the start cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int kill_at, input int poke_at,
                         output int done_cyc, output logic [31:0] res, output int ndone,
                         output logic [63:0] smask);
        done_cyc = -1;
        res = 32'd0;
        ndone = 0;
        smask = 64'd0;
        iStart = 1'b1;
        iOp = op;
        iDividend = a;
        iDivisor = b;
        #1;
        smask[0] = oStall;
        for (int c = 1; c <= 45; c++) begin
            @(negedge iCLK);
            if (c == 1) begin
                iStart = 1'b0;
                iOp = 2'($urandom);
                iDividend = $urandom;
                iDivisor = $urandom;
            end
            if (c == poke_at) begin
                iStart = 1'b1;
                iOp = 2'b01;
                iDividend = 32'd7;
                iDivisor = 32'd1;
            end
            if (c == poke_at + 1) iStart = 1'b0;
            if (c == kill_at) iKill = 1'b1;
            if (c == kill_at + 1) iKill = 1'b0;
            #1;
            if (c < 64) smask[c] = oStall;
            if (oDone) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    res = oResult;
                end
            end
            if (kill_at >= 0 && c == kill_at + 1) break;
            if (done_cyc >= 0 && c == done_cyc + 1) break;
        end
    endtask

    logic [1:0]  d_op  [10] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10};
    logic [31:0] d_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
    logic [31:0] corners [8] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                 32'd2, 32'hFFFF_FFFE, 32'd3};

    initial begin
        int          dc;
        int          nd;
        logic [31:0] res;
        logic [63:0] sm;
        logic [31:0] prior;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        iRST_n = 1'b0;
        iStart = 1'b0;
        iKill = 1'b0;
        iOp = 2'b00;
        iDividend = 32'd0;
        iDivisor = 32'd0;
        repeat (2) @(negedge iCLK);
        chk("reset_busy", {63'd0, oBusy}, 64'd0);
        chk("reset_done", {63'd0, oDone}, 64'd0);
        chk("reset_stall", {63'd0, oStall}, 64'd0);
        chk("reset_result", {32'd0, oResult}, 64'd0);
        iRST_n = 1'b1;
        @(negedge iCLK);

        for (int i = 0; i < 10; i++) begin
            do_op(d_op[i], d_a[i], d_b[i], -1, -1, dc, res, nd, sm);
            chk($sformatf("dir%0d_result", i), {32'd0, res}, {32'd0, d_exp[i]});
            chk($sformatf("dir%0d_latency", i), 64'(dc), (i < 6) ? 64'd34 : 64'd1);
            chk($sformatf("dir%0d_ndone", i), 64'(nd), 64'd1);
            chk($sformatf("dir%0d_stall", i), sm, (i < 6) ? 64'h3_FFFF_FFFF : 64'h1);
            chk($sformatf("dir%0d_hold", i), {32'd0, oResult}, {32'd0, d_exp[i]});
        end
        prior = d_exp[9];

        // Kill in CALC at cycle 10, then restart at cycle 11
        do_op(2'b01, 32'd1000, 32'd3, 10, -1, dc, res, nd, sm);
        chk("kill_ndone", 64'(nd), 64'd0);
        chk("kill_busy", {63'd0, oBusy}, 64'd0);
        chk("kill_result_kept", {32'd0, oResult}, {32'd0, prior});
        do_op(2'b01, 32'd1000, 32'd3, -1, -1, dc, res, nd, sm);
        chk("after_kill_result", {32'd0, res}, 64'd333);
        chk("after_kill_latency", 64'(dc), 64'd34);

        // Start while busy must be ignored
        do_op(2'b01, 32'd1000, 32'd9, -1, 5, dc, res, nd, sm);
        chk("poke_result", {32'd0, res}, 64'd111);
        chk("poke_latency", 64'(dc), 64'd34);
        chk("poke_ndone", 64'(nd), 64'd1);

        // Start together with kill in IDLE is not accepted
        iStart = 1'b1;
        iKill = 1'b1;
        iOp = 2'b01;
        iDividend = 32'd50;
        iDivisor = 32'd0;
        #1;
        chk("startkill_stall", {63'd0, oStall}, 64'd0);
        @(negedge iCLK);
        #1;
        chk("startkill_busy", {63'd0, oBusy}, 64'd0);
        chk("startkill_done", {63'd0, oDone}, 64'd0);
        iStart = 1'b0;
        iKill = 1'b0;
        @(negedge iCLK);
        #1;
        chk("startkill_done2", {63'd0, oDone}, 64'd0);
        chk("startkill_result", {32'd0, oResult}, 64'd111);

        // Asynchronous reset mid-operation
        iStart = 1'b1;
        iOp = 2'b01;
        iDividend = 32'd77;
        iDivisor = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            @(negedge iCLK);
            iStart = 1'b0;
        end
        iRST_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, oBusy}, 64'd0);
        chk("rst_done", {63'd0, oDone}, 64'd0);
        chk("rst_stall", {63'd0, oStall}, 64'd0);
        chk("rst_result", {32'd0, oResult}, 64'd0);
        @(negedge iCLK);
        iRST_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge iCLK);
            #1;
            if (oDone) nd++;
        end
        chk("rst_no_done", 64'(nd), 64'd0);

        // Randomized sweep against the reference model
        for (int i = 0; i < 1200; i++) begin
            op = 2'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            case ($urandom_range(0, 3))
                0: b = corners[$urandom_range(0, 7)];
                1: b = 32'($urandom_range(1, 300));
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op(op, a, b, -1, -1, dc, res, nd, sm);
            chk($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), {32'd0, res}, {32'd0, ref_model(op, a, b)});
            chk($sformatf("rnd%0d_latency", i), 64'(dc), 64'(exp_latency(op, a, b)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
